// File: rtl/bcd_time_pkg.sv
`default_nettype none
// ============================================================================
// bcd_time_pkg : shared edit-state encoding and field limits for bcd_time_core
// Revision 1.0
// ============================================================================
package bcd_time_pkg;

  // State encodings double as the edit_field output value.
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_EDIT_H = 2'b01,
    ST_EDIT_M = 2'b10,
    ST_EDIT_S = 2'b11
  } state_e;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

endpackage
`default_nettype wire

// File: rtl/bcd2_mod_counter.sv
`default_nettype none
// ============================================================================
// bcd2_mod_counter : two-digit BCD counter, 00..MAX, wraps to 00 on inc at MAX
// Revision 1.0
// ============================================================================
module bcd2_mod_counter
  import bcd_time_pkg::*;
#(
  parameter int MAX = SEC_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       wrap
);

  localparam logic [3:0] c_ONES_MAX = 4'(MAX % 10);
  localparam logic [3:0] c_TENS_MAX = 4'(MAX / 10);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;

  assign wrap = inc && (ones_q == c_ONES_MAX) && (tens_q == c_TENS_MAX);

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (wrap) begin
      ones_d = '0;
      tens_d = '0;
    end else if (inc) begin
      if (ones_q == 4'd9) begin
        ones_d = '0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ones_q <= '0;
      tens_q <= '0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones = ones_q;
  assign tens = tens_q;

endmodule
`default_nettype wire

// File: rtl/bcd_time_core.sv
`default_nettype none
// ============================================================================
// bcd_time_core : 1 Hz prescaler, 24h BCD HH:MM:SS clock and field-edit FSM
// Revision 1.0
// ============================================================================
module bcd_time_core
  import bcd_time_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int CNT_W    = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_en,
  input  logic       mode_p,
  input  logic       inc_p,
  output logic [3:0] sec0,
  output logic [3:0] sec1,
  output logic [3:0] min0,
  output logic [3:0] min1,
  output logic [3:0] hour0,
  output logic [3:0] hour1,
  output logic       tick_1hz,
  output logic [1:0] edit_field
);

  localparam logic [CNT_W-1:0] c_CNT_TERM = CNT_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  logic w_run, w_tick, w_edit_inc;
  logic w_sec_inc, w_min_inc, w_hour_inc;
  logic w_sec_wrap, w_min_wrap, w_unused_hour_wrap;

  assign w_run      = (state_q == ST_RUN) && run_en;
  assign w_tick     = w_run && (cnt_q == c_CNT_TERM);
  // mode_p takes priority, so a coincident inc_p is dropped.
  assign w_edit_inc = inc_p && !mode_p;

  // Carries only ride the tick; edit increments never ripple into the next field.
  assign w_sec_inc  = w_tick || (w_edit_inc && (state_q == ST_EDIT_S));
  assign w_min_inc  = (w_tick && w_sec_wrap) || (w_edit_inc && (state_q == ST_EDIT_M));
  assign w_hour_inc = (w_tick && w_sec_wrap && w_min_wrap) ||
                      (w_edit_inc && (state_q == ST_EDIT_H));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (w_run) begin
      cnt_d = (cnt_q == c_CNT_TERM) ? '0 : cnt_q + CNT_W'(1);
    end
    if (mode_p) begin
      case (state_q)
        ST_RUN:    state_d = ST_EDIT_H;
        ST_EDIT_H: state_d = ST_EDIT_M;
        ST_EDIT_M: state_d = ST_EDIT_S;
        ST_EDIT_S: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= w_tick;
    end
  end

  bcd2_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_sec_inc),
    .ones (sec0),
    .tens (sec1),
    .wrap (w_sec_wrap)
  );

  bcd2_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_min_inc),
    .ones (min0),
    .tens (min1),
    .wrap (w_min_wrap)
  );

  bcd2_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_hour_inc),
    .ones (hour0),
    .tens (hour1),
    .wrap (w_unused_hour_wrap)
  );

  assign tick_1hz   = tick_q;
  assign edit_field = state_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_time_core.sv
`default_nettype none
// ============================================================================
// tb_bcd_time_core : directed + random stimulus against a seconds-of-day model
// Revision 1.0
// ============================================================================
module tb_bcd_time_core;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 3;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       run_en = 1'b0;
  logic       mode_p = 1'b0;
  logic       inc_p  = 1'b0;
  logic [3:0] sec0, sec1, min0, min1, hour0, hour1;
  logic       tick_1hz;
  logic [1:0] edit_field;
  logic [23:0] digits;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: time as seconds since midnight, plus edit state and prescaler.
  int m_tod = 0;
  int m_st  = 0;
  int m_pre = 0;
  int m_tick = 0;

  always #5 clk = ~clk;

  bcd_time_core #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .run_en     (run_en),
    .mode_p     (mode_p),
    .inc_p      (inc_p),
    .sec0       (sec0),
    .sec1       (sec1),
    .min0       (min0),
    .min1       (min1),
    .hour0      (hour0),
    .hour1      (hour1),
    .tick_1hz   (tick_1hz),
    .edit_field (edit_field)
  );

  assign digits = {hour1, hour0, min1, min0, sec1, sec0};

  function automatic logic [23:0] bcd_of(input int tod);
    int h, m, s;
    h = tod / 3600;
    m = (tod / 60) % 60;
    s = tod % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int h, m, s;
    if (!rst) begin
      m_tod = 0; m_st = 0; m_pre = 0; m_tick = 0;
    end else begin
      m_tick = 0;
      if (m_st == 0 && run_en) begin
        if (m_pre == TICK_DIV - 1) begin
          m_pre  = 0;
          m_tick = 1;
          m_tod  = (m_tod + 1) % 86400;
        end else begin
          m_pre++;
        end
      end
      h = m_tod / 3600;
      m = (m_tod / 60) % 60;
      s = m_tod % 60;
      if (mode_p) begin
        if (m_st == 3) m_pre = 0;
        m_st = (m_st + 1) % 4;
      end else if (inc_p) begin
        case (m_st)
          1: h = (h + 1) % 24;
          2: m = (m + 1) % 60;
          3: s = (s + 1) % 60;
          default: ;
        endcase
        m_tod = h * 3600 + m * 60 + s;
      end
    end
  endtask

  task automatic compare_all();
    chk("digits", {8'h0, digits}, {8'h0, bcd_of(m_tod)});
    chk("tick_1hz", {31'h0, tick_1hz}, m_tick);
    chk("edit_field", {30'h0, edit_field}, m_st);
  endtask

  // One clock: inputs held across the edge, model stepped, outputs sampled 1 ns later.
  task automatic cyc(input bit m, input bit i);
    mode_p = m;
    inc_p  = i;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    mode_p = 1'b0;
    inc_p  = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cyc(0, 0);
      n++;
    end while (!tick_1hz && n < 20);
    if (!tick_1hz) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  // Walks the edit FSM from RUN back to RUN, landing on h:m:s with the prescaler at 0.
  task automatic set_time(input int h, input int m, input int s);
    run_en = 1'b0;
    cyc(1, 0);
    repeat ((h - m_tod / 3600 + 24) % 24) cyc(0, 1);
    cyc(1, 0);
    repeat ((m - (m_tod / 60) % 60 + 60) % 60) cyc(0, 1);
    cyc(1, 0);
    repeat ((s - m_tod % 60 + 60) % 60) cyc(0, 1);
    cyc(1, 0);
  endtask

  initial begin
    int n;
    logic [23:0] held;

    rst = 1'b0;
    cyc(0, 0);
    cyc(0, 0);
    chk("reset_digits", {8'h0, digits}, 32'h0);
    chk("reset_field", {30'h0, edit_field}, 32'd0);
    chk("reset_tick", {31'h0, tick_1hz}, 32'd0);

    rst = 1'b1;
    run_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_tick(n);
      chk("tick_period", n, TICK_DIV);
    end
    chk("three_ticks", {8'h0, digits}, 32'h000003);

    set_time(0, 0, 59);
    run_en = 1'b1;
    wait_tick(n);
    chk("first_tick_after_edit", n, TICK_DIV);
    chk("sec_carry", {8'h0, digits}, 32'h000100);

    set_time(0, 59, 59);
    run_en = 1'b1;
    wait_tick(n);
    chk("min_carry", {8'h0, digits}, 32'h010000);

    set_time(23, 59, 59);
    run_en = 1'b1;
    wait_tick(n);
    chk("day_wrap", {8'h0, digits}, 32'h000000);

    cyc(0, 0);
    cyc(0, 0);
    run_en = 1'b0;
    held = digits;
    repeat (20) cyc(0, 0);
    chk("hold_digits", {8'h0, digits}, {8'h0, held});
    run_en = 1'b1;
    wait_tick(n);
    chk("resume_remaining", n, 2);

    set_time(0, 0, 0);
    cyc(1, 0);
    repeat (25) cyc(0, 1);
    chk("hour_edit_wrap", {8'h0, digits}, 32'h010000);
    cyc(1, 0);
    repeat (61) cyc(0, 1);
    chk("min_edit_wrap", {8'h0, digits}, 32'h010100);
    cyc(1, 0);
    cyc(1, 0);
    cyc(1, 0);
    chk("in_edit_h", {30'h0, edit_field}, 32'd1);
    cyc(1, 1);
    chk("mode_wins_field", {30'h0, edit_field}, 32'd2);
    chk("mode_wins_digits", {8'h0, digits}, 32'h010100);
    cyc(1, 0);
    run_en = 1'b1;
    cyc(1, 0);
    wait_tick(n);
    chk("exit_edit_tick", n, TICK_DIV);

    set_time(12, 34, 56);
    cyc(1, 0);
    cyc(1, 0);
    chk("pre_reset_field", {30'h0, edit_field}, 32'd2);
    rst = 1'b0;
    #3;
    chk("async_rst_ignored", {8'h0, digits}, 32'h123456);
    cyc(1, 1);
    chk("mid_edit_reset", {8'h0, digits}, 32'h0);
    chk("mid_edit_reset_field", {30'h0, edit_field}, 32'd0);
    rst = 1'b1;

    for (int k = 0; k < 1500; k++) begin
      rst    = ($urandom % 300) != 0;
      run_en = ($urandom % 4) != 0;
      cyc(($urandom % 12) == 0, ($urandom % 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
